// File: rtl/tholin_namebadge_if.sv
// Tile-side 8-bit I/O bus for the name-badge driver: io_in carries clock, reset
// and effect pins; io_out carries the LCD pins and the two LEDs.
interface tholin_namebadge_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface

// File: rtl/tholin_namebadge.sv
// HD44780 4-bit name-badge driver: initialises the LCD, writes "Tholin", then
// applies a periodic blink/shift effect chosen by io_in[4:2].
module tholin_namebadge (
`ifdef USE_POWER_PINS
  inout wire vccd1,
  inout wire vssd1,
`endif
  tholin_namebadge_if.slave bus
);

  typedef enum logic [2:0] {
    ST_STARTUP, ST_INIT_NIB, ST_INIT_CMD, ST_CLR_WAIT,
    ST_MSG, ST_WAIT, ST_STEP, ST_XFER
  } state_t;

  logic       clk, rst;
  logic [2:0] ef;
  logic       unused_pins;

  assign clk         = bus.io_in[0];
  assign rst         = bus.io_in[1];
  assign ef          = bus.io_in[4:2];
  assign unused_pins = &{1'b0, bus.io_in[7:5]};

  state_t     state, state_n;
  logic [9:0] cnt, cnt_n;
  logic [2:0] sub, sub_n;
  logic [2:0] idx, idx_n;
  logic [7:0] xbyte, xbyte_n, xnext, xnext_n;
  logic       xmore, xmore_n;
  logic       disp_on, disp_on_n;
  logic       rs, rs_n, e, e_n, led0, led0_n, led1, led1_n;
  logic [3:0] dout, dout_n;

  logic       slot_on, slot_rs;
  logic [7:0] slot_byte;
  logic       blink, shift, has_xfer, two_xfer;
  logic [7:0] first_b, second_b, shift_b;

  assign bus.io_out = {led1, led0, dout, e, rs};

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i[1:0])
      2'd0:    return 8'h28;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] msg_byte(input logic [2:0] i);
    case (i)
      3'd0:    return 8'h54;
      3'd1:    return 8'h68;
      3'd2:    return 8'h6F;
      3'd3:    return 8'h6C;
      3'd4:    return 8'h69;
      3'd5:    return 8'h6E;
      default: return 8'h00;
    endcase
  endfunction

  // Effect decode: a dark display is always restored before any non-blink action.
  always_comb begin
    blink    = (ef == 3'b001);
    shift    = (ef == 3'b010) || (ef == 3'b011);
    shift_b  = ef[0] ? 8'h1C : 8'h18;
    first_b  = 8'h00;
    second_b = 8'h00;
    has_xfer = 1'b0;
    two_xfer = 1'b0;
    if (blink) begin
      first_b  = disp_on ? 8'h08 : 8'h0C;
      has_xfer = 1'b1;
    end else if (!disp_on) begin
      first_b  = 8'h0C;
      second_b = shift_b;
      has_xfer = 1'b1;
      two_xfer = shift;
    end else if (shift) begin
      first_b  = shift_b;
      has_xfer = 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sub_n     = sub;
    idx_n     = idx;
    xbyte_n   = xbyte;
    xnext_n   = xnext;
    xmore_n   = xmore;
    disp_on_n = disp_on;
    rs_n      = rs;
    e_n       = e;
    dout_n    = dout;
    led0_n    = led0;
    led1_n    = led1;
    slot_on   = 1'b0;
    slot_rs   = 1'b0;
    slot_byte = 8'h00;

    case (state)
      ST_STARTUP: begin
        cnt_n = cnt + 10'd1;
        if (cnt == 10'd31) begin
          state_n = ST_INIT_NIB;
          cnt_n   = '0;
        end
      end
      ST_INIT_NIB: begin
        slot_on   = !sub[2];
        slot_byte = (idx == 3'd3) ? 8'h20 : 8'h30;
        sub_n     = sub + 3'd1;
        if (sub == 3'd7) begin
          idx_n = idx + 3'd1;
          if (idx == 3'd3) begin
            state_n = ST_INIT_CMD;
            idx_n   = '0;
          end
        end
      end
      ST_INIT_CMD: begin
        slot_on   = 1'b1;
        slot_byte = init_cmd(idx);
        sub_n     = sub + 3'd1;
        if (sub == 3'd7) begin
          idx_n = idx + 3'd1;
          if (idx == 3'd3) begin
            state_n = ST_CLR_WAIT;
            idx_n   = '0;
            cnt_n   = '0;
          end
        end
      end
      ST_CLR_WAIT: begin
        cnt_n = cnt + 10'd1;
        if (cnt == 10'd31) begin
          state_n = ST_MSG;
          cnt_n   = '0;
        end
      end
      ST_MSG: begin
        slot_on   = 1'b1;
        slot_rs   = 1'b1;
        slot_byte = msg_byte(idx);
        sub_n     = sub + 3'd1;
        if (sub == 3'd7) begin
          idx_n = idx + 3'd1;
          if (idx == 3'd5) begin
            state_n = ST_WAIT;
            idx_n   = '0;
            cnt_n   = '0;
          end
        end
      end
      ST_WAIT: begin
        cnt_n = cnt + 10'd1;
        if (cnt == 10'd1023) begin
          state_n = ST_STEP;
          cnt_n   = '0;
        end
      end
      // The STEP edge doubles as the first transfer cycle, or as the first
      // wait cycle when nothing is sent, keeping the step period exact.
      ST_STEP: begin
        led0_n    = ~led0;
        led1_n    = |ef;
        disp_on_n = blink ? ~disp_on : 1'b1;
        if (has_xfer) begin
          slot_on   = 1'b1;
          slot_byte = first_b;
          sub_n     = 3'd1;
          xbyte_n   = first_b;
          xnext_n   = second_b;
          xmore_n   = two_xfer;
          state_n   = ST_XFER;
        end else begin
          state_n = ST_WAIT;
          cnt_n   = 10'd1;
        end
      end
      ST_XFER: begin
        slot_on   = 1'b1;
        slot_byte = xbyte;
        sub_n     = sub + 3'd1;
        if (sub == 3'd7) begin
          if (xmore) begin
            xbyte_n = xnext;
            xmore_n = 1'b0;
          end else begin
            state_n = ST_WAIT;
            cnt_n   = '0;
          end
        end
      end
      default: state_n = ST_STARTUP;
    endcase

    if (slot_on) begin
      case (sub[1:0])
        2'd0: begin
          rs_n   = slot_rs;
          dout_n = sub[2] ? slot_byte[3:0] : slot_byte[7:4];
          e_n    = 1'b0;
        end
        2'd1, 2'd2: e_n = 1'b1;
        default:    e_n = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_STARTUP;
      cnt     <= '0;
      sub     <= '0;
      idx     <= '0;
      xbyte   <= '0;
      xnext   <= '0;
      xmore   <= 1'b0;
      disp_on <= 1'b1;
      rs      <= 1'b0;
      e       <= 1'b0;
      dout    <= '0;
      led0    <= 1'b0;
      led1    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sub     <= sub_n;
      idx     <= idx_n;
      xbyte   <= xbyte_n;
      xnext   <= xnext_n;
      xmore   <= xmore_n;
      disp_on <= disp_on_n;
      rs      <= rs_n;
      e       <= e_n;
      dout    <= dout_n;
      led0    <= led0_n;
      led1    <= led1_n;
    end
  end

endmodule

// File: tb/tb_tholin_namebadge.sv
// Self-checking bench for tholin_namebadge: decodes LCD strobes into timed
// nibble events and compares them with tabled and modelled expectations.
module tb_tholin_namebadge;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [2:0] ef   = '0;
  logic [2:0] junk = '0;

  tholin_namebadge_if bus ();
  assign bus.io_in = {junk, ef, rst, clk};

  tholin_namebadge dut (.bus(bus));

  always #5 clk = ~clk;

  int cyc = -1;
  always @(posedge clk) begin
    if (rst) cyc <= -1;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int         rise;
    int         fall;
    logic       rs;
    logic [3:0] nib;
  } ev_t;

  ev_t        evq[$];
  ev_t        expq[$];
  logic       prev_e  = 1'b0;
  int         rise_c  = 0;
  logic       rise_rs = 1'b0;
  logic [3:0] rise_nib = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_e <= 1'b0;
    end else begin
      if (bus.io_out[1] && !prev_e) begin
        rise_c   <= cyc;
        rise_rs  <= bus.io_out[0];
        rise_nib <= bus.io_out[5:2];
      end
      if (!bus.io_out[1] && prev_e)
        evq.push_back('{rise_c, cyc, rise_rs, rise_nib});
      prev_e <= bus.io_out[1];
    end
  end

  int total = 0;
  int bad   = 0;
  int T     = 0;
  int stepno = 0;
  bit disp  = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pk(input int r, input int f, input logic rs, input logic [3:0] n);
    return {16'(r), 16'(f), 27'd0, rs, n};
  endfunction

  task automatic wait_cycle(input int c);
    int guard = 0;
    while (cyc < c) begin
      @(negedge clk);
      #1;
      guard++;
      if (guard > 5000) begin
        $display("FAIL wait_cycle: stuck at cycle %0d waiting for %0d", cyc, c);
        $fatal(1, "wait bound expired");
      end
    end
  endtask

  task automatic push_nib(input int t, input logic rs, input logic [3:0] n);
    expq.push_back('{t + 1, t + 3, rs, n});
  endtask

  task automatic push_byte(input int t, input logic rs, input logic [7:0] b);
    push_nib(t, rs, b[7:4]);
    push_nib(t + 4, rs, b[3:0]);
  endtask

  // Behavioural effect rules: the list of bytes one STEP sends, and the display flag after it.
  function automatic void model_step(input logic [2:0] e, inout bit d, output int n,
                                     output logic [15:0] by);
    logic [7:0] q[$];
    if (e == 3'b001) begin
      q.push_back(d ? 8'h08 : 8'h0C);
      d = !d;
    end else begin
      if (!d) begin
        q.push_back(8'h0C);
        d = 1'b1;
      end
      if (e == 3'b010)      q.push_back(8'h18);
      else if (e == 3'b011) q.push_back(8'h1C);
    end
    n  = q.size();
    by = '0;
    if (n > 0) by[15:8] = q[0];
    if (n > 1) by[7:0]  = q[1];
  endfunction

  task automatic run_step(input logic [2:0] e, input int n, input logic [15:0] bytes,
                          input string tag);
    ev_t        x;
    logic [7:0] b;
    wait_cycle(T - 1);
    check({tag, " quiet"}, 64'(evq.size()), 64'd0);
    evq.delete();
    ef = e;
    wait_cycle(T);
    stepno++;
    check({tag, " led0"}, 64'(bus.io_out[6]), 64'(stepno % 2));
    check({tag, " led1"}, 64'(bus.io_out[7]), 64'(|e));
    ef   = 3'($urandom);
    junk = 3'($urandom);
    wait_cycle(T + 18);
    check({tag, " count"}, 64'(evq.size()), 64'(2 * n));
    for (int j = 0; j < n; j++) begin
      b = (j == 0) ? bytes[15:8] : bytes[7:0];
      for (int h = 0; h < 2; h++) begin
        if (evq.size() != 0) begin
          x = evq.pop_front();
          check({tag, " nibble"}, pk(x.rise, x.fall, x.rs, x.nib),
                pk(T + 1 + 8 * j + 4 * h, T + 3 + 8 * j + 4 * h, 1'b0,
                   (h == 0) ? b[7:4] : b[3:0]));
        end
      end
    end
    evq.delete();
    T = T + 1024 + 8 * n;
  endtask

  typedef struct {
    logic [2:0]  ef;
    int          n;
    logic [15:0] bytes;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int          dn;
    logic [15:0] dby;
    logic [2:0]  re;
    ev_t         x;
    ev_t         y;

    tbl[0]  = '{3'b001, 1, 16'h0800};
    tbl[1]  = '{3'b001, 1, 16'h0C00};
    tbl[2]  = '{3'b001, 1, 16'h0800};
    tbl[3]  = '{3'b010, 2, 16'h0C18};
    tbl[4]  = '{3'b000, 0, 16'h0000};
    tbl[5]  = '{3'b011, 1, 16'h1C00};
    tbl[6]  = '{3'b001, 1, 16'h0800};
    tbl[7]  = '{3'b100, 1, 16'h0C00};
    tbl[8]  = '{3'b110, 0, 16'h0000};
    tbl[9]  = '{3'b001, 1, 16'h0800};
    tbl[10] = '{3'b000, 1, 16'h0C00};
    tbl[11] = '{3'b010, 1, 16'h1800};

    repeat (4) @(negedge clk);
    #1;
    check("reset io_out", 64'(bus.io_out), 64'd0);
    rst = 1'b0;

    for (int c = 0; c < 32; c++) begin
      wait_cycle(c);
      check("startup idle", 64'(bus.io_out), 64'd0);
    end

    for (int i = 0; i < 3; i++) push_nib(32 + 8 * i, 1'b0, 4'h3);
    push_nib(56, 1'b0, 4'h2);
    push_byte(64, 1'b0, 8'h28);
    push_byte(72, 1'b0, 8'h0C);
    push_byte(80, 1'b0, 8'h06);
    push_byte(88, 1'b0, 8'h01);
    push_byte(128, 1'b1, 8'h54);
    push_byte(136, 1'b1, 8'h68);
    push_byte(144, 1'b1, 8'h6F);
    push_byte(152, 1'b1, 8'h6C);
    push_byte(160, 1'b1, 8'h69);
    push_byte(168, 1'b1, 8'h6E);

    wait_cycle(190);
    check("init count", 64'(evq.size()), 64'(expq.size()));
    while (evq.size() != 0 && expq.size() != 0) begin
      x = evq.pop_front();
      y = expq.pop_front();
      check("init stream", pk(x.rise, x.fall, x.rs, x.nib), pk(y.rise, y.fall, y.rs, y.nib));
    end
    evq.delete();
    expq.delete();

    T = 1200;
    for (int i = 0; i < 12; i++) begin
      run_step(tbl[i].ef, tbl[i].n, tbl[i].bytes, "table");
      model_step(tbl[i].ef, disp, dn, dby);
    end

    for (int i = 0; i < 8; i++) begin
      re = 3'($urandom);
      model_step(re, disp, dn, dby);
      run_step(re, dn, dby, "random");
    end

    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    wait_cycle(129);
    check("msg strobe high", 64'({bus.io_out[1], bus.io_out[0]}), 64'h3);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("reset mid-strobe", 64'(bus.io_out), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    evq.delete();
    rst = 1'b0;
    wait_cycle(31);
    check("reboot idle", 64'(bus.io_out), 64'd0);
    wait_cycle(36);
    check("reboot count", 64'(evq.size()), 64'd1);
    if (evq.size() != 0) begin
      x = evq.pop_front();
      check("reboot first nibble", pk(x.rise, x.fall, x.rs, x.nib), pk(33, 35, 1'b0, 4'h3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
